// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and divider helper for the seven-segment counter
package seven_seg_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } counter_state_t;

    // A zero tick rate yields 0 so the caller's elaboration check can reject it.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return (tick_hz > 0) ? (clk_hz / tick_hz) : 0;
    endfunction

endpackage

// File: rtl/next_digit.sv
// rtl/next_digit.sv - combinational BCD incrementer, all 9s wraps to all 0s
module next_digit
    import seven_seg_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  bcd_digit_t [DIGITS-1:0] digits_i,
    output bcd_digit_t [DIGITS-1:0] digits_o
);

    logic carry;

    always_comb begin
        digits_o = digits_i;
        carry    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (digits_i[i] == 4'd9) begin
                    digits_o[i] = 4'd0;
                end else begin
                    digits_o[i] = digits_i[i] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// rtl/bcd_tick_counter.sv - BCD count register with prescaled tick, run/stop, step and clear
module bcd_tick_counter
    import seven_seg_pkg::*;
#(
    parameter int DIGITS  = 6,
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    step,
    input  logic                    clear,
    output bcd_digit_t [DIGITS-1:0] bcd,
    output logic                    tick,
    output logic                    rollover,
    output logic                    running
);

    localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    if (TICK_HZ <= 0 || DIV < 1 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
        $error("bcd_tick_counter: CLK_HZ / TICK_HZ must be an integer >= 1");
    end

    counter_state_t          state_q, state_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic                    step_q, step_d;
    bcd_digit_t [DIGITS-1:0] bcd_q, bcd_d;
    bcd_digit_t [DIGITS-1:0] bcd_inc;
    logic                    tick_q, tick_d;
    logic                    rollover_q, rollover_d;
    logic                    advance;
    logic                    all_nines;

    next_digit #(.DIGITS(DIGITS)) u_next_digit (
        .digits_i (bcd_q),
        .digits_o (bcd_inc)
    );

    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i] != 4'd9) begin
                all_nines = 1'b0;
            end
        end
    end

    // Step edges only count while stopped; a held step advances once.
    always_comb begin
        advance = ((state_q == RUNNING) && (pre_q == PRE_MAX)) ||
                  ((state_q == STOPPED) && step && !step_q);

        state_d    = run ? RUNNING : STOPPED;
        step_d     = step;
        pre_d      = '0;
        bcd_d      = bcd_q;
        tick_d     = 1'b0;
        rollover_d = 1'b0;

        if (!clear && (state_q == RUNNING) && (pre_q != PRE_MAX)) begin
            pre_d = pre_q + PRE_W'(1);
        end

        if (clear) begin
            bcd_d = '0;
        end else if (advance) begin
            bcd_d      = bcd_inc;
            tick_d     = 1'b1;
            rollover_d = all_nines;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= STOPPED;
            pre_q      <= '0;
            step_q     <= 1'b0;
            bcd_q      <= '0;
            tick_q     <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            step_q     <= step_d;
            bcd_q      <= bcd_d;
            tick_q     <= tick_d;
            rollover_q <= rollover_d;
        end
    end

    assign bcd      = bcd_q;
    assign tick     = tick_q;
    assign rollover = rollover_q;
    assign running  = (state_q == RUNNING);

endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Sequential BCD counter core for the DE10-Lite seven-segment counter design. It holds the DIGITS-wide BCD count register and divides the board clock into a count-rate tick. On each tick it advances the count through the combinational `next_digit` incrementer. It also supports run/stop, single-step and clear control. Its `bcd` output feeds the per-digit seven-segment decoders downstream.

## Interface
Parameters:
- DIGITS, 6, number of BCD digits; digit 0 is least significant.
- CLK_HZ, 50_000_000, `clk` frequency in Hz.
- TICK_HZ, 10, count rate in Hz while running.
- Derived: DIV = CLK_HZ / TICK_HZ.
  - Must be an integer ≥ 1; elaboration error otherwise.
  - Prescaler width = max(1, $clog2(DIV)).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = count continuously, 0 = stopped. Synchronous to `clk`; synchronizers sit upstream.
- step  in  1  level; a rising edge while stopped advances the count by one. Synchronous to `clk`.
- clear  in  1  level; while 1, the count and prescaler are held at 0.
- bcd  out  [DIGITS-1:0][3:0]  current count.
- tick  out  1  one-cycle pulse, coincident with the first cycle of each new `bcd` value.
- rollover  out  1  one-cycle pulse, coincident with `tick`, when the count wraps from all 9s to all 0s.
- running  out  1  1 when the state is RUNNING.

## Operation
- State machine, one register:
  - STOPPED → RUNNING when run=1.
  - RUNNING → STOPPED when run=0.
  - Transitions take effect at the next rising edge. `clear` does not change the state.
- Prescaler `pre`:
  - In RUNNING it counts 0..DIV-1 and wraps to 0.
  - In STOPPED it is forced to 0, so every run restarts a full period.
- Advance event, computed from registered state:
  - (state==RUNNING && pre==DIV-1), or
  - (state==STOPPED && step && !step_q), where `step_q` is step registered every cycle in both states.
  - Step edges in RUNNING are ignored.
- On an advance with clear=0:
  - bcd ← next_digit(bcd).
  - tick ← 1.
  - rollover ← 1 if every digit of the old bcd is 9.
- clear has priority over an advance:
  - bcd ← 0 and pre ← 0.
  - tick and rollover ← 0; the suppressed advance is lost.
- Otherwise bcd holds, and tick and rollover are 0.
- bcd digits are always in the range 0–9; no digit ever holds A–F.
- Reset values:
  - bcd = 0, tick = 0, rollover = 0, running = 0.
  - State = STOPPED, pre = 0, step_q = 0.
- Reset may assert at any point mid-count; all registers return to their reset values immediately, with no partial update.

## Timing
- run 0→1 sampled at edge E: running=1 after E, and the first advance registers at edge E+DIV.
- After that, one advance every DIV cycles. With DIV=1, one advance per cycle.
- run 1→0 sampled at edge E with pre==DIV-1: the advance still occurs at E, because state was RUNNING.
- step edge sampled at edge E while STOPPED: bcd updates and tick pulses immediately after E. One-cycle latency.
- step held high produces exactly one advance.
- clear sampled at E: bcd=0 after E. When clear deasserts in RUNNING, the next advance is DIV cycles later.
- tick and rollover are registered and glitch-free; each is high for exactly one cycle.
- No combinational path from inputs to outputs.

## Structure
- Package `seven_seg_pkg`:
  - `bcd_digit_t` (logic [3:0]).
  - Enum `counter_state_t` {STOPPED, RUNNING}.
  - Function `calc_div(clk_hz, tick_hz)`.
- Sub-module: the existing combinational incrementer `next_digit` (parameter DIGITS passed through), instantiated once on the bcd register.
- The all-9s detect for rollover is local logic.
- Estimated size: about 150 lines of RTL.

## Test plan
All scenarios use DIGITS=2, CLK_HZ=4, TICK_HZ=1 (DIV=4).
- Reset, then run=1 → bcd=00 until the 4th edge after running=1; then 01, 02, 03 at 4-cycle spacing, with one tick per step.
- Preload 98 via steps, then run → 98→99 (no rollover), then 99→00 with tick=1 and rollover=1 in the same cycle.
- STOPPED, step held high for 10 cycles → exactly one increment. step pulsed 3 times → bcd=03. step pulses while running → no extra increments.
- Running at bcd=37, assert clear on the cycle pre==3 → bcd=00 and tick=0. After clear drops, 01 appears exactly 4 cycles later.
- run dropped with pre==3 → the final increment occurs. run dropped with pre==1 → no increment; restart takes a full 4 cycles.
- Assert reset asynchronously mid-period at bcd=55 → bcd=00, tick=0, rollover=0 and running=0 before the next clock edge.
